// File: rtl/accumulator_control_unit.sv
// accumulator_control_unit: fetch/decode/execute sequencer for the 16-bit accumulator computer; ports: clock, reset_n, start, ir, acc_zero -> PC/MAR/MBR/IR/ACC load and selects, alu_op, mem_write, busy, halted, instr_done; CTRL_SINGLE_STEP_EN adds a step input and a PAUSE state between instructions
module accumulator_control_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [15:0] ir,
  input  logic        acc_zero,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        mar_write,
  output logic        mar_sel,
  output logic        mbr_write,
  output logic        mbr_sel,
  output logic        ir_write,
  output logic        acc_write,
  output logic [1:0]  acc_sel,
  output logic [3:0]  alu_op,
  output logic        mem_write,
  output logic        busy,
  output logic        halted,
  output logic        instr_done
);
  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_SHL   = 4'h7;
  localparam logic [3:0] OP_SHR   = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_JNZ   = 4'hB;
  localparam logic [3:0] OP_CLR   = 4'hC;
  localparam logic [3:0] OP_CMPEQ = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [3:0] {
    IDLE, F_ADDR, F_READ, F_IR, DECODE, E_ADDR, E_READ, E_MBR, E_ACC, E_STORE, E_WRITE, HALTED
`ifdef CTRL_SINGLE_STEP_EN
    , PAUSE
`endif
  } state_t;

`ifdef CTRL_SINGLE_STEP_EN
  localparam state_t NEXT_I = PAUSE;
`else
  localparam state_t NEXT_I = F_ADDR;
`endif

  state_t state, state_n;
  logic [3:0] op;
  logic [3:0] opc;
  logic unused_ir;

  assign opc = ir[15:12];
  assign unused_ir = ^ir[11:0];

  function automatic logic [3:0] alu_code(input logic [3:0] o);
    return o == OP_SUB   ? 4'b0001 :
           o == OP_AND   ? 4'b1000 :
           o == OP_OR    ? 4'b1001 :
           o == OP_XOR   ? 4'b1010 :
           o == OP_SHL   ? 4'b0100 :
           o == OP_SHR   ? 4'b0101 :
           o == OP_CMPEQ ? 4'b1111 : 4'b0000;
  endfunction

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      op    <= OP_LOAD;
    end else begin
      state <= state_n;
      op    <= state == DECODE ? opc : op;
    end

  always_comb begin
    state_n    = state;
    pc_write   = 1'b0;
    pc_sel     = 1'b0;
    mar_write  = 1'b0;
    mar_sel    = 1'b0;
    mbr_write  = 1'b0;
    mbr_sel    = 1'b0;
    ir_write   = 1'b0;
    acc_write  = 1'b0;
    acc_sel    = 2'd0;
    alu_op     = 4'b0000;
    mem_write  = 1'b0;
    instr_done = 1'b0;
    case (state)
      IDLE:    state_n = start ? F_ADDR : IDLE;
      F_ADDR:  begin
        mar_write = 1'b1;
        state_n   = F_READ;
      end
      F_READ:  begin
        pc_write = 1'b1;
        state_n  = F_IR;
      end
      F_IR:    begin
        ir_write = 1'b1;
        state_n  = DECODE;
      end
      DECODE:  begin
        instr_done = 1'b1;
        state_n    = NEXT_I;
        case (opc)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMPEQ: begin
            instr_done = 1'b0;
            state_n    = E_ADDR;
          end
          OP_SHL, OP_SHR: begin
            acc_write = 1'b1;
            alu_op    = alu_code(opc);
          end
          OP_JMP:  begin
            pc_write = 1'b1;
            pc_sel   = 1'b1;
          end
          OP_JZ:   begin
            pc_write = acc_zero;
            pc_sel   = acc_zero;
          end
          OP_JNZ:  begin
            pc_write = !acc_zero;
            pc_sel   = !acc_zero;
          end
          OP_CLR:  begin
            acc_write = 1'b1;
            acc_sel   = 2'd2;
          end
          OP_HALT: state_n = HALTED;
          default: ;
        endcase
      end
      E_ADDR:  begin
        mar_write = 1'b1;
        mar_sel   = 1'b1;
        state_n   = op == OP_STORE ? E_STORE : E_READ;
      end
      E_READ:  state_n = E_MBR;
      E_MBR:   begin
        mbr_write = 1'b1;
        state_n   = E_ACC;
      end
      E_ACC:   begin
        acc_write  = 1'b1;
        acc_sel    = op == OP_LOAD ? 2'd1 : 2'd0;
        alu_op     = alu_code(op);
        instr_done = 1'b1;
        state_n    = NEXT_I;
      end
      E_STORE: begin
        mbr_write = 1'b1;
        mbr_sel   = 1'b1;
        state_n   = E_WRITE;
      end
      E_WRITE: begin
        mem_write  = 1'b1;
        instr_done = 1'b1;
        state_n    = NEXT_I;
      end
      HALTED:  state_n = HALTED;
`ifdef CTRL_SINGLE_STEP_EN
      PAUSE:   state_n = step ? F_ADDR : PAUSE;
`endif
      default: state_n = IDLE;
    endcase
  end

  assign busy   = state != IDLE && state != HALTED;
  assign halted = state == HALTED;
endmodule

// File: tb/tb_accumulator_control_unit.sv
// tb_accumulator_control_unit: bench with datapath/memory around the controller and an instruction-level reference model
module tb_accumulator_control_unit;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
  localparam int SS = 1;
  logic step = 1'b1;
`else
  localparam int SS = 0;
`endif
  logic [15:0] ir;
  logic acc_zero;
  logic pc_write, pc_sel, mar_write, mar_sel, mbr_write, mbr_sel, ir_write, acc_write;
  logic [1:0] acc_sel;
  logic [3:0] alu_op;
  logic mem_write, busy, halted, instr_done;
  logic [17:0] outs;

  always #5 clock = ~clock;

  accumulator_control_unit dut (
    .clock(clock), .reset_n(reset_n), .start(start),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .ir(ir), .acc_zero(acc_zero),
    .pc_write(pc_write), .pc_sel(pc_sel), .mar_write(mar_write), .mar_sel(mar_sel),
    .mbr_write(mbr_write), .mbr_sel(mbr_sel), .ir_write(ir_write), .acc_write(acc_write),
    .acc_sel(acc_sel), .alu_op(alu_op), .mem_write(mem_write), .busy(busy),
    .halted(halted), .instr_done(instr_done)
  );

  assign outs = {pc_write, pc_sel, mar_write, mar_sel, mbr_write, mbr_sel, ir_write, acc_write,
                 acc_sel, alu_op, mem_write, busy, halted, instr_done};

  logic [15:0] mem [0:4095];
  logic [15:0] acc, mar, mbr, pc, data_out;
  logic ld_en = 1'b0;
  logic [11:0] ld_addr = 12'h0;
  logic [15:0] ld_data = 16'h0;

  function automatic logic [15:0] alu(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    case (c)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b1010: return a ^ b;
      4'b0100: return a << 1;
      4'b0101: return a >> 1;
      4'b1111: return {15'h0, a == b};
      default: return 16'hDEAD;
    endcase
  endfunction

  always @(posedge clock) begin
    if (ld_en) mem[ld_addr] = ld_data;
    else if (mem_write) mem[mar[11:0]] = mbr;
    data_out <= mem[mar[11:0]];
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      acc <= '0; mar <= '0; mbr <= '0; pc <= '0; ir <= '0;
    end else begin
      if (pc_write) pc <= pc_sel ? {4'h0, ir[11:0]} : pc + 16'd1;
      if (mar_write) mar <= mar_sel ? {4'h0, ir[11:0]} : pc;
      if (mbr_write) mbr <= mbr_sel ? acc : data_out;
      if (ir_write) ir <= data_out;
      if (acc_write) acc <= acc_sel == 2'd0 ? alu(alu_op, acc, mbr) : acc_sel == 2'd1 ? mbr : 16'h0;
    end

  assign acc_zero = acc == 16'h0;

  int checks = 0;
  int failures = 0;
  int extra = 0;
  logic [15:0] ref_mem [0:4095];
  logic [15:0] ref_acc, ref_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock)
    if (reset_n) check("exclusive_writes", {30'h0, acc_write & mem_write, mar_write & mbr_write}, 32'h0);

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en = 1'b1;
    ref_mem[a] = d;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic begin_reset();
    @(negedge clock);
    reset_n = 1'b0;
    ref_acc = 16'h0;
    ref_pc = 16'h0;
    @(negedge clock);
  endtask

  task automatic launch();
    reset_n = 1'b1;
    start = 1'b1;
    extra = 0;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("launch_f_addr", {busy, mar_write, mar_sel}, 3'b110);
  endtask

  task automatic wait_done(output int n, output int nmw, output int nst, output logic [2:0] fin, output logic [3:0] fop);
    n = 0; nmw = 0; nst = 0;
    do begin
      @(negedge clock);
      n++;
      nmw += int'(mem_write);
      nst += int'(mbr_write && mbr_sel);
    end while (!instr_done && n < 40);
    fin = {acc_write, pc_write, mem_write};
    fop = alu_op;
    check("instr_done_seen", instr_done, 1'b1);
  endtask

  task automatic ref_step(output int cyc, output logic h, output logic st, output logic [11:0] sa,
                          output logic [2:0] efin, output logic [3:0] ea, output logic eav);
    logic [15:0] ins, m;
    logic [3:0] o;
    logic [11:0] a;
    ins = ref_mem[ref_pc[11:0]];
    ref_pc = ref_pc + 16'd1;
    o = ins[15:12];
    a = ins[11:0];
    m = ref_mem[a];
    cyc = 8; h = 1'b0; st = 1'b0; sa = a; efin = 3'b100; ea = 4'b0000; eav = 1'b1;
    case (o)
      4'h0: begin ref_acc = m; eav = 1'b0; end
      4'h1: begin ref_mem[a] = ref_acc; cyc = 7; st = 1'b1; efin = 3'b001; eav = 1'b0; end
      4'h2: ref_acc = ref_acc + m;
      4'h3: begin ref_acc = ref_acc - m; ea = 4'b0001; end
      4'h4: begin ref_acc = ref_acc & m; ea = 4'b1000; end
      4'h5: begin ref_acc = ref_acc | m; ea = 4'b1001; end
      4'h6: begin ref_acc = ref_acc ^ m; ea = 4'b1010; end
      4'h7: begin ref_acc = ref_acc << 1; ea = 4'b0100; cyc = 4; end
      4'h8: begin ref_acc = ref_acc >> 1; ea = 4'b0101; cyc = 4; end
      4'hE: begin ref_acc = {15'h0, ref_acc == m}; ea = 4'b1111; end
      4'hC: begin ref_acc = 16'h0; cyc = 4; eav = 1'b0; end
      default: begin
        cyc = 4; eav = 1'b0; efin = 3'b000;
        if (o == 4'h9 || (o == 4'hA && ref_acc == 0) || (o == 4'hB && ref_acc != 0)) begin
          ref_pc = {4'h0, a};
          efin = 3'b010;
        end
        h = o == 4'hF;
      end
    endcase
  endtask

  task automatic exec_check(input string tag);
    int n, nmw, nst, ec;
    logic [2:0] fin, efin;
    logic [3:0] fop, ea;
    logic h, st, eav;
    logic [11:0] sa;
    wait_done(n, nmw, nst, fin, fop);
    ref_step(ec, h, st, sa, efin, ea, eav);
    check({tag, "_cycles"}, n, ec + extra);
    check({tag, "_final_enables"}, fin, efin);
    if (eav) check({tag, "_alu_op"}, fop, ea);
    check({tag, "_mem_write_cycles"}, nmw, int'(st));
    check({tag, "_mbr_from_acc_cycles"}, nst, int'(st));
    @(posedge clock);
    #1;
    check({tag, "_acc"}, acc, ref_acc);
    check({tag, "_pc"}, pc, ref_pc);
    check({tag, "_halted"}, halted, h);
    if (st) check({tag, "_mem"}, mem[sa], ref_mem[sa]);
    extra = h ? 0 : SS;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b1;
    begin_reset();
    for (int k = 0; k < 4; k++) begin
      start = k[0];
      @(negedge clock);
      check("reset_outputs", outs, 18'h0);
    end
    poke(12'h000, 16'h0010);
    poke(12'h001, 16'h2011);
    poke(12'h002, 16'hF000);
    poke(12'h010, 16'd5);
    poke(12'h011, 16'd7);
    launch();
    exec_check("load");
    exec_check("add");
    exec_check("halt");
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      start = ~start;
      check("halted_ignores_start", outs, 18'h2);
    end
    start = 1'b0;

    begin_reset();
    check("reset_after_halt", outs, 18'h0);
    poke(12'h000, 16'h0030);
    poke(12'h001, 16'h1020);
    poke(12'h002, 16'hF000);
    poke(12'h030, 16'h1234);
    poke(12'h020, 16'h0000);
    launch();
    exec_check("store_load");
    exec_check("store");
    exec_check("store_halt");

    begin_reset();
    poke(12'h000, 16'hC000);
    poke(12'h001, 16'hA040);
    poke(12'h040, 16'h0050);
    poke(12'h050, 16'd3);
    poke(12'h041, 16'hA060);
    poke(12'h042, 16'hB045);
    poke(12'h045, 16'hF000);
    launch();
    exec_check("clr");
    exec_check("jz_taken");
    exec_check("load3");
    exec_check("jz_not_taken");
    exec_check("jnz_taken");
    exec_check("jump_halt");

    begin_reset();
    poke(12'h000, 16'h0030);
    poke(12'h001, 16'h1020);
    poke(12'h020, 16'hBEEF);
    launch();
    exec_check("abort_load");
    for (int k = 0; k < 20 && !mem_write; k++) @(negedge clock);
    check("abort_saw_mem_write", mem_write, 1'b1);
    reset_n = 1'b0;
    #1;
    check("abort_outputs", outs, 18'h0);
    @(posedge clock);
    #1;
    check("abort_mem_untouched", mem[12'h020], 16'hBEEF);

    begin_reset();
    for (int i = 0; i < 64; i++) begin
      logic [3:0] o;
      logic [11:0] a;
      o = 4'($urandom_range(0, 14));
      a = (o == 4'h9 || o == 4'hA || o == 4'hB) ? 12'($urandom_range(0, 64)) : {4'h1, 8'($urandom)};
      poke(12'(i), {o, a});
    end
    poke(12'h040, 16'h9000);
    for (int i = 0; i < 256; i++)
      poke(12'h100 + 12'(i), $urandom_range(0, 1) ? 16'($urandom_range(0, 3)) : 16'($urandom));
    launch();
    for (int i = 0; i < 250; i++) exec_check("random");

`ifdef CTRL_SINGLE_STEP_EN
    begin_reset();
    poke(12'h000, 16'hD000);
    poke(12'h001, 16'hD000);
    poke(12'h002, 16'hF000);
    step = 1'b0;
    launch();
    exec_check("step_nop1");
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("pause_hold", outs, 18'h4);
    end
    step = 1'b1;
    @(posedge clock);
    #1;
    check("pause_to_fetch", {busy, mar_write, mar_sel}, 3'b110);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
